// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one execution-unit result per cycle (round-robin
// with a bounded fast path for requester 0) and drives it from a single output register.
module cdb_arbiter #(
  parameter int N_EU   = 4,
  parameter int DATA_W = 64,
  parameter int HP_EN  = 1,
  parameter int HP_MAX = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic [N_EU-1:0]           eu_valid_i,
  output logic [N_EU-1:0]           eu_ready_o,
  input  logic [N_EU*DATA_W-1:0]    eu_data_i,
  input  logic                      cdb_ready_i,
  output logic                      cdb_valid_o,
  output logic [DATA_W-1:0]         cdb_data_o,
  output logic [$clog2(N_EU)-1:0]   cdb_src_o
);

  localparam int SRC_W = $clog2(N_EU);
  localparam int HPC_W = $clog2(HP_MAX + 1);

  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [SRC_W-1:0]    src_q, src_d;
  logic [SRC_W-1:0]    rr_q, rr_d;
  logic [HPC_W-1:0]    hp_cnt_q, hp_cnt_d;

  logic                out_en;
  logic                any_valid;
  logic                others_valid;
  logic                hp_take;
  logic [N_EU-1:0]     rr_mask;
  logic [2*N_EU-1:0]   rr_rot;
  logic                rr_found;
  logic [SRC_W-1:0]    rr_win;
  logic [SRC_W-1:0]    win;
  int                  w_int;
  logic [DATA_W-1:0]   eu_data_arr [N_EU];

  for (genvar g = 0; g < N_EU; g++) begin : g_unpack
    assign eu_data_arr[g] = eu_data_i[g*DATA_W +: DATA_W];
  end

  function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] idx);
    if (32'(idx) == N_EU - 1) return '0;
    return idx + 1'b1;
  endfunction

  function automatic logic [HPC_W-1:0] sat_inc(input logic [HPC_W-1:0] cnt);
    if (32'(cnt) >= HP_MAX) return HPC_W'(HP_MAX);
    return cnt + 1'b1;
  endfunction

  // Once requester 0 has used up its priority budget it is kept out of the
  // round-robin scan, so the bound actually lets a competing unit through.
  always_comb begin
    rr_mask = eu_valid_i;
    if (HP_EN != 0) rr_mask[0] = 1'b0;
    rr_rot   = {rr_mask, rr_mask} >> rr_q;
    rr_found = 1'b0;
    rr_win   = '0;
    w_int    = 0;
    for (int k = 0; k < N_EU; k++) begin
      if (!rr_found && rr_rot[k]) begin
        rr_found = 1'b1;
        w_int    = int'(rr_q) + k;
        if (w_int >= N_EU) w_int = w_int - N_EU;
        rr_win   = SRC_W'(w_int);
      end
    end
  end

  always_comb begin
    out_en       = !valid_q || cdb_ready_i;
    any_valid    = |eu_valid_i;
    others_valid = |eu_valid_i[N_EU-1:1];
    hp_take      = (HP_EN != 0) && eu_valid_i[0] &&
                   (!others_valid || (32'(hp_cnt_q) < HP_MAX));
    win          = hp_take ? '0 : rr_win;

    eu_ready_o = '0;
    valid_d    = valid_q;
    data_d     = data_q;
    src_d      = src_q;
    rr_d       = rr_q;
    hp_cnt_d   = hp_cnt_q;

    if (flush_i) begin
      valid_d  = 1'b0;
      hp_cnt_d = '0;
    end else if (out_en) begin
      if (any_valid) begin
        eu_ready_o[win] = 1'b1;
        valid_d         = 1'b1;
        data_d          = eu_data_arr[win];
        src_d           = win;
        if (hp_take) begin
          hp_cnt_d = others_valid ? sat_inc(hp_cnt_q) : '0;
        end else begin
          rr_d     = wrap_inc(win);
          hp_cnt_d = '0;
        end
      end else begin
        valid_d = 1'b0;
      end
    end

    if (rst_i) eu_ready_o = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      src_q    <= '0;
      rr_q     <= '0;
      hp_cnt_q <= '0;
    end else begin
      valid_q  <= valid_d;
      data_q   <= data_d;
      src_q    <= src_d;
      rr_q     <= rr_d;
      hp_cnt_q <= hp_cnt_d;
    end
  end

  assign cdb_valid_o = valid_q;
  assign cdb_data_o  = data_q;
  assign cdb_src_o   = src_q;

  a_ready_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(eu_ready_o));

  a_stall_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (valid_q && !cdb_ready_i) |=> ($stable(data_q) && $stable(src_q)));

endmodule
